// File: rtl/uart_simplex_tx.sv
// ============================================================================
// uart_simplex_tx
// ----------------------------------------------------------------------------
// Transmit-only UART serializer. A byte offered with a one-cycle start request
// is captured and shifted out on a single serial line. The frame is a start
// bit (0), eight data bits LSB first, an optional even-parity bit and a stop
// bit (1). Every serial bit is held for CLKS_PER_BIT system clocks.
//
// Configuration macro:
//   UART_PARITY_EN  when defined, an even-parity bit (XOR of D0..D7) is sent
//                   between D7 and the stop bit, giving an 11-bit frame.
//                   When undefined the frame is 10 bits.
//
// Parameters:
//   CLKS_PER_BIT    system clocks per serial bit, legal range 1..65535
//
// Ports:
//   i_CLK        in   1  system clock, rising edge
//   i_RST        in   1  synchronous active-high reset
//   i_TX_ENABLE  in   1  start request, only looked at while idle
//   i_DATA_IN    in   8  byte to send, captured on the accepting edge
//   o_TX         out  1  registered serial line, idles high
//   o_BUSY       out  1  high while a frame is in progress
//   o_DONE       out  1  one-cycle pulse when a stop bit completes
// ============================================================================
module uart_simplex_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic       i_TX_ENABLE,
    input  logic [7:0] i_DATA_IN,
    output logic       o_TX,
    output logic       o_BUSY,
    output logic       o_DONE
);

    // The baud counter needs at least one bit even when CLKS_PER_BIT is 1;
    // in that case it simply stays at zero and every cycle is a bit tick.
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef UART_PARITY_EN
    // One extra shift-register bit carries the parity bit behind D7.
    localparam int unsigned SHIFT_W    = 10;
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned SHIFT_W    = 9;
    localparam int unsigned FRAME_BITS = 10;
`endif

    // Index of the stop bit; its final tick ends the frame.
    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    typedef enum logic {
        IDLE     = 1'b0,
        TRANSMIT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [SHIFT_W-1:0]   txShift_q, txShift_d;
    logic [3:0]           bitCount_q, bitCount_d;
    logic [BAUD_W-1:0]    baudCount_q, baudCount_d;
    logic                 txLine_q, txLine_d;
    logic                 done_q, done_d;

    logic                 baudTick;
    logic [SHIFT_W-1:0]   loadValue;

    // Frame image loaded on acceptance. Bit 0 is the start bit so the line
    // can be driven straight from the shift register's LSB; stop bits come
    // from the ones shifted in at the top.
`ifdef UART_PARITY_EN
    assign loadValue = {^i_DATA_IN, i_DATA_IN, 1'b0};
`else
    assign loadValue = {i_DATA_IN, 1'b0};
`endif

    assign baudTick = (baudCount_q == BAUD_LAST);

    // Next-state logic. Enable is only honoured in IDLE, so requests that
    // arrive mid-frame are dropped rather than queued. The serial line is
    // computed from the next-state values so that o_TX is a flop output that
    // already shows the start bit in the cycle after acceptance.
    always_comb begin
        state_d     = state_q;
        txShift_d   = txShift_q;
        bitCount_d  = bitCount_q;
        baudCount_d = baudCount_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_TX_ENABLE) begin
                    txShift_d   = loadValue;
                    bitCount_d  = 4'd0;
                    baudCount_d = '0;
                    state_d     = TRANSMIT;
                end
            end

            TRANSMIT: begin
                if (baudTick) begin
                    baudCount_d = '0;
                    txShift_d   = {1'b1, txShift_q[SHIFT_W-1:1]};
                    if (bitCount_q == LAST_BIT) begin
                        // Stop bit finished: leave with a done pulse and
                        // park the counter so it never runs past the frame.
                        state_d    = IDLE;
                        done_d     = 1'b1;
                        bitCount_d = 4'd0;
                    end else begin
                        bitCount_d = bitCount_q + 4'd1;
                    end
                end else begin
                    baudCount_d = baudCount_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        txLine_d = (state_d == TRANSMIT) ? txShift_d[0] : 1'b1;
    end

    // State and datapath registers. Reset has priority over everything and
    // aborts any frame in flight; the line goes back to its idle-high level.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q     <= IDLE;
            txShift_q   <= '0;
            bitCount_q  <= 4'd0;
            baudCount_q <= '0;
            txLine_q    <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            txShift_q   <= txShift_d;
            bitCount_q  <= bitCount_d;
            baudCount_q <= baudCount_d;
            txLine_q    <= txLine_d;
            done_q      <= done_d;
        end
    end

    assign o_TX   = txLine_q;
    assign o_BUSY = (state_q == TRANSMIT);
    assign o_DONE = done_q;

endmodule

// File: tb/tb_uart_simplex_tx.sv
// ============================================================================
// tb_uart_simplex_tx
// ----------------------------------------------------------------------------
// Bench for uart_simplex_tx. Two instances run side by side: one with one
// clock per bit and one with sixteen. Expected serial sequences are written
// out by hand in transmit order (first transmitted data bit in bit 7 of the
// seq field). Honours UART_PARITY_EN the same way the design does.
// ============================================================================
module tb_uart_simplex_tx;

`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk;
    logic       rst;
    logic       enF, enS;
    logic [7:0] dataF, dataS;
    logic       txF, busyF, doneF;
    logic       txS, busyS, doneS;

    int asserts  = 0;
    int failures = 0;

    typedef struct {
        bit         fast;
        logic [7:0] data;
        logic [7:0] seq;
        logic       par;
    } vec_t;

    vec_t vecs[8];

    uart_simplex_tx #(.CLKS_PER_BIT(1)) dutFast (
        .i_CLK      (clk),
        .i_RST      (rst),
        .i_TX_ENABLE(enF),
        .i_DATA_IN  (dataF),
        .o_TX       (txF),
        .o_BUSY     (busyF),
        .o_DONE     (doneF)
    );

    uart_simplex_tx #(.CLKS_PER_BIT(16)) dutSlow (
        .i_CLK      (clk),
        .i_RST      (rst),
        .i_TX_ENABLE(enS),
        .i_DATA_IN  (dataS),
        .o_TX       (txS),
        .o_BUSY     (busyS),
        .o_DONE     (doneS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: every check goes through here.
    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected line level for frame bit b.
    function automatic logic expBit(input logic [7:0] seq, input logic par, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return seq[8-b];
        if (NBITS == 11 && b == 9) return par;
        return 1'b1;
    endfunction

    // Raise the start request on the chosen instance; accept edge follows.
    task automatic applyStimulus(input bit fast, input logic [7:0] data);
        @(negedge clk);
        if (fast) begin
            enF = 1'b1; dataF = data;
        end else begin
            enS = 1'b1; dataS = data;
        end
    endtask

    // Walks a whole frame starting at the first cycle after acceptance.
    task automatic checkFrameBits(input bit fast, input logic [7:0] seq, input logic par,
                                  input string name, input bit holdEn,
                                  input int pulseAt, input logic [7:0] pulseData);
        int   cpb;
        int   cyc;
        int   busyCnt;
        int   doneCnt;
        logic tx, bad, badTx, lastTx, eb;
        cpb = fast ? 1 : 16;
        cyc = 0; busyCnt = 0; doneCnt = 0;
        for (int b = 0; b < NBITS; b++) begin
            bad = 1'b0; badTx = 1'b0; lastTx = 1'b0;
            eb  = expBit(seq, par, b);
            for (int c = 0; c < cpb; c++) begin
                @(negedge clk);
                if (!holdEn) begin
                    enF = 1'b0; enS = 1'b0;
                    if (cyc == 0) begin
                        if (fast) dataF = ~dataF; else dataS = ~dataS;
                    end
                end
                if (cyc == pulseAt) begin
                    if (fast) begin enF = 1'b1; dataF = pulseData; end
                    else      begin enS = 1'b1; dataS = pulseData; end
                end
                tx = fast ? txF : txS;
                if (tx !== eb && !bad) begin
                    bad = 1'b1; badTx = tx;
                end
                lastTx  = tx;
                busyCnt += int'(fast ? busyF : busyS);
                doneCnt += int'(fast ? doneF : doneS);
                cyc++;
            end
            checkVal($sformatf("%s bit%0d tx", name, b), {31'd0, bad ? badTx : lastTx}, {31'd0, eb});
        end
        checkVal($sformatf("%s busy cycles", name), busyCnt, NBITS * cpb);
        checkVal($sformatf("%s done inside frame", name), doneCnt, 0);
    endtask

    // First cycle after the stop bit: line high, busy low, done pulsing.
    task automatic checkOutput(input bit fast, input string name);
        @(negedge clk);
        if (fast) checkVal({name, " end tx/busy/done"}, {29'd0, txF, busyF, doneF}, 32'b101);
        else      checkVal({name, " end tx/busy/done"}, {29'd0, txS, busyS, doneS}, 32'b101);
    endtask

    // Line must stay idle with no done pulse for n cycles.
    task automatic checkIdle(input bit fast, input int n, input string name);
        int badCnt;
        badCnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            enF = 1'b0; enS = 1'b0;
            if (fast) begin
                if ({txF, busyF, doneF} !== 3'b100) badCnt++;
            end else begin
                if ({txS, busyS, doneS} !== 3'b100) badCnt++;
            end
        end
        checkVal({name, " idle cycles not idle"}, badCnt, 0);
    endtask

    task automatic runFrame(input bit fast, input logic [7:0] data, input logic [7:0] seq,
                            input logic par, input string name);
        applyStimulus(fast, data);
        checkFrameBits(fast, seq, par, name, 1'b0, -1, 8'h00);
        checkOutput(fast, name);
        checkIdle(fast, 3, name);
    endtask

    initial begin
        //           fast  data   seq (transmit order)  parity
        vecs[0] = '{1'b1, 8'h2A, 8'b01010100, 1'b1};
        vecs[1] = '{1'b0, 8'hA5, 8'b10100101, 1'b0};
        vecs[2] = '{1'b1, 8'hFF, 8'b11111111, 1'b0};
        vecs[3] = '{1'b1, 8'h00, 8'b00000000, 1'b0};
        vecs[4] = '{1'b0, 8'h07, 8'b11100000, 1'b1};
        vecs[5] = '{1'b1, 8'h03, 8'b11000000, 1'b0};
        vecs[6] = '{1'b1, 8'h80, 8'b00000001, 1'b1};
        vecs[7] = '{1'b0, 8'h55, 8'b10101010, 1'b0};

        rst = 1'b1; enF = 1'b0; enS = 1'b0; dataF = 8'h00; dataS = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        $display("[TB] reset and idle");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkVal($sformatf("reset idle cycle%0d", i),
                     {26'd0, txF, busyF, doneF, txS, busyS, doneS}, 32'b100100);
        end

        $display("[TB] table vectors");
        for (int i = 0; i < 8; i++)
            runFrame(vecs[i].fast, vecs[i].data, vecs[i].seq, vecs[i].par,
                     $sformatf("vec%0d_%02h", i, vecs[i].data));

        $display("[TB] back-to-back frames");
        applyStimulus(1'b1, 8'h81);
        @(posedge clk);
        #1 dataF = 8'h3C;
        checkFrameBits(1'b1, 8'b10000001, 1'b0, "b2b first", 1'b1, -1, 8'h00);
        checkOutput(1'b1, "b2b first");
        checkFrameBits(1'b1, 8'b00111100, 1'b0, "b2b second", 1'b0, -1, 8'h00);
        checkOutput(1'b1, "b2b second");
        checkIdle(1'b1, 5, "b2b after");

        $display("[TB] enable pulsed mid-frame");
        applyStimulus(1'b0, 8'h5A);
        checkFrameBits(1'b0, 8'b01011010, 1'b0, "midpulse", 1'b0, 50, 8'hC3);
        checkOutput(1'b0, "midpulse");
        checkIdle(1'b0, 40, "midpulse after");

        $display("[TB] reset mid-frame");
        applyStimulus(1'b0, 8'h3C);
        @(posedge clk);
        for (int i = 0; i < 69; i++) begin
            @(negedge clk);
            enS = 1'b0;
        end
        checkVal("abort reached bit4", {31'd0, busyS}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkVal("abort tx/busy/done", {29'd0, txS, busyS, doneS}, 32'b100);
        rst = 1'b0;
        checkIdle(1'b0, 40, "abort no resume");
        runFrame(1'b0, 8'h55, 8'b10101010, 1'b0, "after abort 55");

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
